ps2_scancode_rx: RTL and testbench

- PS/2 keyboard front end for the synthesizer; sits directly upstream of gui and the note logic, replacing the raw keyboard byte path.
- Oversamples PS2_CLK/PS2_DAT on CLOCK_50, deframes 11-bit device-to-host frames and checks parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into single decoded key events with a one-cycle valid strobe.

---
 rtl/ps2_scancode_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver for the synthesizer front end.
// Oversamples PS2_CLK/PS2_DAT on the system clock and deframes 11-bit frames.
// Each frame is checked for odd parity and for a stop bit of 1.
// E0/F0 prefixes are folded into one key event, marked by a one-cycle key_valid.
// Optional feature macro: PS2_HOLD_MAP_EN enables the notes_held bitmap.
// When the macro is not defined, notes_held is tied to zero.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_ext,
    output logic       frame_error,
    output logic [7:0] notes_held
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the edge where the counter would reach TIMEOUT_CYCLES.
    // That edge is exactly TIMEOUT_CYCLES clocks after the edge that consumed the last fall.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // 1 when the data ones plus the parity bit give an odd count.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic clk_s1_q, clk_s2_q, clk_dly_q;
    logic dat_s1_q, dat_s2_q;
    logic fall_s, bit_s;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_break_q, key_break_d;
    logic          key_ext_q, key_ext_d;
    logic          frame_error_q, frame_error_d;

    // Two-flop synchronizers (idle-high) plus a delay flop for clk fall detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            clk_dly_q <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            clk_dly_q <= clk_s2_q;
            dat_s1_q  <= ps2_dat;
            dat_s2_q  <= dat_s1_q;
        end
    end

    assign fall_s = clk_dly_q & ~clk_s2_q;
    assign bit_s  = dat_s2_q;

    // Frame FSM, timeout watchdog, prefix folding and output next-state.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        to_cnt_d      = to_cnt_q;
        ext_d         = ext_q;
        brk_d         = brk_q;
        key_valid_d   = 1'b0;
        key_code_d    = key_code_q;
        key_break_d   = key_break_q;
        key_ext_d     = key_ext_q;
        frame_error_d = 1'b0;

        if (fall_s) begin
            // A fall always wins over a simultaneous timeout.
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!bit_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {bit_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_d   = bit_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (bit_s && odd_parity_ok(shift_q, par_q)) begin
                        if (shift_q == 8'hE0) begin
                            ext_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            brk_d = 1'b1;
                        end else begin
                            key_valid_d = 1'b1;
                            key_code_d  = shift_q;
                            key_break_d = brk_q;
                            key_ext_d   = ext_q;
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        ext_d         = 1'b0;
                        brk_d         = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            frame_error_d = 1'b1;
            state_d       = ST_IDLE;
            to_cnt_d      = '0;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
        end else begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            to_cnt_q      <= '0;
            ext_q         <= 1'b0;
            brk_q         <= 1'b0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_break_q   <= 1'b0;
            key_ext_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            to_cnt_q      <= to_cnt_d;
            ext_q         <= ext_d;
            brk_q         <= brk_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_break_q   <= key_break_d;
            key_ext_q     <= key_ext_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_break   = key_break_q;
    assign key_ext     = key_ext_q;
    assign frame_error = frame_error_q;

`ifdef PS2_HOLD_MAP_EN
    logic [7:0] notes_q, notes_d;

    // One-hot note position for the home-row keys A..K; other codes map to nothing.
    function automatic logic [7:0] note_onehot(input logic [7:0] code);
        case (code)
            8'h1C:   return 8'h01;
            8'h1B:   return 8'h02;
            8'h23:   return 8'h04;
            8'h2B:   return 8'h08;
            8'h34:   return 8'h10;
            8'h33:   return 8'h20;
            8'h3B:   return 8'h40;
            8'h42:   return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    // Held-note bitmap follows non-extended make/break events.
    always_comb begin
        notes_d = notes_q;
        if (key_valid_d && !key_ext_d) begin
            if (key_break_d) begin
                notes_d = notes_q & ~note_onehot(key_code_d);
            end else begin
                notes_d = notes_q | note_onehot(key_code_d);
            end
        end else begin
            notes_d = notes_q;
        end
    end

    // Bitmap register, updated together with key_valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            notes_q <= 8'h00;
        end else begin
            notes_q <= notes_d;
        end
    end

    assign notes_held = notes_q;
`else
    assign notes_held = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed testbench for ps2_scancode_rx.
// Uses a short PS/2 bit period of 40 clocks and a timeout of 1000 cycles.
module tb_ps2_scancode_rx;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       frame_error;
    logic [7:0] notes_held;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(1000)) dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_break   (key_break),
        .key_ext     (key_ext),
        .frame_error (frame_error),
        .notes_held  (notes_held)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;
    int kv_cyc = 0;
    int fe_cyc = 0;
    int both_cnt = 0;
    int last_fall = 0;
    int kv0, fe0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (key_valid) begin
            kv_cnt <= kv_cnt + 1;
            kv_cyc <= cyc;
        end
        if (frame_error) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (key_valid && frame_error) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_notes(input logic [7:0] v);
`ifdef PS2_HOLD_MAP_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        wait_neg(10);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_neg(20);
        ps2_clk = 1'b1;
        wait_neg(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        wait_neg(5);
    endtask

    initial begin
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        wait_neg(4);
        chk("rst_kv", {31'd0, key_valid}, 32'd0);
        chk("rst_fe", {31'd0, frame_error}, 32'd0);
        chk("rst_code", {24'd0, key_code}, 32'd0);
        chk("rst_notes", {24'd0, notes_held}, 32'd0);
        reset = 1'b0;
        wait_neg(5);

        // Make of A (0x1C)
        send_frame(8'h1C, 1'b0);
        chk("t1_kvcnt", kv_cnt, 1);
        chk("t1_lat", kv_cyc - last_fall, 3);
        chk("t1_code", {24'd0, key_code}, 32'h1C);
        chk("t1_brk", {31'd0, key_break}, 32'd0);
        chk("t1_ext", {31'd0, key_ext}, 32'd0);
        chk("t1_notes", {24'd0, notes_held}, {24'd0, exp_notes(8'h01)});

        // Break of A
        send_frame(8'hF0, 1'b0);
        chk("t2_noevt", kv_cnt, 1);
        send_frame(8'h1C, 1'b0);
        chk("t2_kvcnt", kv_cnt, 2);
        chk("t2_code", {24'd0, key_code}, 32'h1C);
        chk("t2_brk", {31'd0, key_break}, 32'd1);
        chk("t2_ext", {31'd0, key_ext}, 32'd0);
        chk("t2_notes", {24'd0, notes_held}, 32'd0);

        // Extended break E0 F0 75
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        chk("t3_kvcnt", kv_cnt, 3);
        chk("t3_code", {24'd0, key_code}, 32'h75);
        chk("t3_brk", {31'd0, key_break}, 32'd1);
        chk("t3_ext", {31'd0, key_ext}, 32'd1);
        chk("t3_notes", {24'd0, notes_held}, 32'd0);

        // Parity error, then the good frame
        send_frame(8'h1B, 1'b1);
        chk("t4_fecnt", fe_cnt, 1);
        chk("t4_kvcnt", kv_cnt, 3);
        send_frame(8'h1B, 1'b0);
        chk("t4b_kvcnt", kv_cnt, 4);
        chk("t4b_code", {24'd0, key_code}, 32'h1B);
        chk("t4b_brk", {31'd0, key_break}, 32'd0);
        chk("t4b_ext", {31'd0, key_ext}, 32'd0);
        chk("t4b_notes", {24'd0, notes_held}, {24'd0, exp_notes(8'h02)});

        // Timeout: start + 3 data bits of 0x23, then idle
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        wait_neg(1100);
        chk("t5_fecnt", fe_cnt, 2);
        chk("t5_fedly", fe_cyc - last_fall, 1003);
        chk("t5_kvcnt", kv_cnt, 4);
        send_frame(8'h23, 1'b0);
        chk("t5b_kvcnt", kv_cnt, 5);
        chk("t5b_code", {24'd0, key_code}, 32'h23);
        chk("t5b_notes", {24'd0, notes_held}, {24'd0, exp_notes(8'h06)});

        // Reset in the middle of 0x2B
        fe0 = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        reset = 1'b1;
        wait_neg(3);
        chk("t6_rst_kv", {31'd0, key_valid}, 32'd0);
        chk("t6_rst_code", {24'd0, key_code}, 32'd0);
        chk("t6_rst_brk", {31'd0, key_break}, 32'd0);
        chk("t6_rst_ext", {31'd0, key_ext}, 32'd0);
        chk("t6_rst_notes", {24'd0, notes_held}, 32'd0);
        reset = 1'b0;
        wait_neg(5);
        kv0 = kv_cnt;
        send_frame(8'h2B, 1'b0);
        chk("t6_fe", fe_cnt - fe0, 0);
        chk("t6_kv", kv_cnt - kv0, 1);
        chk("t6_code", {24'd0, key_code}, 32'h2B);
        chk("t6_notes", {24'd0, notes_held}, {24'd0, exp_notes(8'h08)});

        // Error clears a pending break prefix
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b1);
        send_frame(8'h1C, 1'b0);
        chk("t7_fe", fe_cnt - fe0, 1);
        chk("t7_kv", kv_cnt - kv0, 2);
        chk("t7_code", {24'd0, key_code}, 32'h1C);
        chk("t7_brk", {31'd0, key_break}, 32'd0);
        chk("t7_notes", {24'd0, notes_held}, {24'd0, exp_notes(8'h09)});

        chk("excl", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
